// File: rtl/memory_arbiter.sv
// Arbitrates instruction fetches and data reads/writes onto one variable-latency RAM port.
// Define MEMARB_PERF_EN to add icount/dcount/stall performance counters.
module memory_arbiter #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_WORD       = 32'hBAD0BAD0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic        halt,
  output logic        ihit,
  output logic [31:0] iload,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        merr,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
`ifdef MEMARB_PERF_EN
  ,
  output logic [31:0] icount,
  output logic [31:0] dcount,
  output logic [31:0] stall
`endif
);

  typedef enum logic [1:0] {IDLE, IACC, DACC, DONE} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [1:0] RAM_ERROR  = 2'b11;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, store_reg, wait_cnt_reg;
  logic        wr_reg, is_d_reg;
  logic        in_access, ram_ok, ram_fail;

  assign in_access = (state_reg == IACC) || (state_reg == DACC);
  assign ram_ok    = (ramstate == RAM_ACCESS);
  assign ram_fail  = !ram_ok &&
                     ((ramstate == RAM_ERROR) || (wait_cnt_reg == 32'(TIMEOUT_CYCLES - 1)));
  assign ramaddr   = addr_reg;
  assign ramstore  = store_reg;

  always_comb begin
    state_next = state_reg;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ihit       = 1'b0;
    dhit       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dWEN || dREN)       state_next = DACC;
        else if (iREN && !halt) state_next = IACC;
      end
      IACC: begin
        ramREN = 1'b1;
        if (ram_ok || ram_fail) state_next = DONE;
      end
      DACC: begin
        ramWEN = wr_reg;
        ramREN = !wr_reg;
        if (ram_ok || ram_fail) state_next = DONE;
      end
      DONE: begin
        // One idle cycle after the hit so a still-held request is not served twice.
        ihit       = !is_d_reg;
        dhit       = is_d_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      store_reg    <= '0;
      wr_reg       <= 1'b0;
      is_d_reg     <= 1'b0;
      wait_cnt_reg <= '0;
      iload        <= '0;
      dload        <= '0;
      merr         <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && state_next != IDLE) begin
        addr_reg  <= (dWEN || dREN) ? daddr : iaddr;
        store_reg <= dstore;
        wr_reg    <= dWEN;
        is_d_reg  <= dWEN || dREN;
      end
      if (in_access) begin
        if (ram_ok || ram_fail) begin
          wait_cnt_reg <= '0;
          if (!is_d_reg)    iload <= ram_ok ? ramload : ERR_WORD;
          else if (!wr_reg) dload <= ram_ok ? ramload : ERR_WORD;
          if (ram_fail) merr <= 1'b1;
        end else begin
          wait_cnt_reg <= wait_cnt_reg + 32'd1;
        end
      end
    end
  end

`ifdef MEMARB_PERF_EN
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      icount <= '0;
      dcount <= '0;
      stall  <= '0;
    end else begin
      if (ihit) icount <= icount + 32'd1;
      if (dhit) dcount <= dcount + 32'd1;
      if ((iREN || dREN || dWEN) && !ihit && !dhit) stall <= stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed testbench for memory_arbiter; the bench plays the RAM by driving ramstate/ramload each cycle.
module tb_memory_arbiter;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, halt;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        ihit, dhit, merr, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACC = 2'b10;

  memory_arbiter #(.TIMEOUT_CYCLES(8), .ERR_WORD(32'hBAD0BAD0)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .halt(halt), .ihit(ihit), .iload(iload),
    .dhit(dhit), .dload(dload), .merr(merr), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0; halt = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
    tick(); tick();
    if ({ihit, dhit, merr, ramREN, ramWEN} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {ihit, dhit, merr, ramREN, ramWEN});
    end
    checks++;
    if ({iload, dload, ramaddr, ramstore} !== 128'b0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {iload, dload, ramaddr, ramstore});
    end
    checks++;
    nRST = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_fetch();
    iREN = 1; iaddr = 32'h40; ramstate = ACC; ramload = 32'h3C010001;
    if (ramREN !== 1'b0) begin failures++; $display("FAIL t1_idle_strobe got=%b exp=0", ramREN); end
    checks++;
    tick();
    if (ramREN !== 1'b1 || ramaddr !== 32'h40 || ihit !== 1'b0) begin
      failures++; $display("FAIL t1_iacc ren=%b addr=%h ihit=%b exp 1/40/0", ramREN, ramaddr, ihit);
    end
    checks++;
    tick();
    if (ihit !== 1'b1 || iload !== 32'h3C010001 || ramREN !== 1'b0) begin
      failures++; $display("FAIL t1_hit ihit=%b iload=%h ren=%b exp 1/3c010001/0", ihit, iload, ramREN);
    end
    checks++;
    iREN = 0;
    tick();
    if (ihit !== 1'b0) begin failures++; $display("FAIL t1_pulse ihit=%b exp=0", ihit); end
    checks++;
    $display("test_fetch addr=40 iload=%h", iload);
  endtask

  task automatic test_priority();
    iREN = 1; iaddr = 32'h44; dREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'hDEADBEEF;
    ramstate = ACC; ramload = 32'h11112222;
    tick();
    if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h80 || ramstore !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL t2_write wen=%b ren=%b addr=%h st=%h exp 1/0/80/deadbeef", ramWEN, ramREN, ramaddr, ramstore);
    end
    checks++;
    tick();
    if (dhit !== 1'b1 || ihit !== 1'b0 || dload !== 32'h0) begin
      failures++; $display("FAIL t2_dhit dhit=%b ihit=%b dload=%h exp 1/0/0", dhit, ihit, dload);
    end
    checks++;
    dREN = 0; dWEN = 0;
    tick();
    if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin
      failures++; $display("FAIL t2_idle ren=%b wen=%b exp 0/0", ramREN, ramWEN);
    end
    checks++;
    tick();
    if (ramREN !== 1'b1 || ramaddr !== 32'h44) begin
      failures++; $display("FAIL t2_fetch ren=%b addr=%h exp 1/44", ramREN, ramaddr);
    end
    checks++;
    tick();
    if (ihit !== 1'b1 || iload !== 32'h11112222) begin
      failures++; $display("FAIL t2_ihit ihit=%b iload=%h exp 1/11112222", ihit, iload);
    end
    checks++;
    iREN = 0;
    tick();
    $display("test_priority write 80 then fetch 44");
  endtask

  task automatic test_wait_states();
    dREN = 1; daddr = 32'h100; ramstate = BUSY;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (ramREN !== 1'b1 || dhit !== 1'b0) begin
        failures++; $display("FAIL t3_busy cyc=%0d ren=%b dhit=%b exp 1/0", k, ramREN, dhit);
      end
      checks++;
    end
    tick();
    ramstate = ACC; ramload = 32'h1234;
    if (dhit !== 1'b0) begin failures++; $display("FAIL t3_early dhit=%b exp=0", dhit); end
    checks++;
    tick();
    if (dhit !== 1'b1 || dload !== 32'h1234) begin
      failures++; $display("FAIL t3_hit dhit=%b dload=%h exp 1/1234", dhit, dload);
    end
    checks++;
    dREN = 0;
    tick();
    $display("test_wait_states dload=%h", dload);
  endtask

  task automatic test_timeout();
    dREN = 1; daddr = 32'h200; ramstate = BUSY; ramload = 32'h7777;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (dhit !== 1'b0 || merr !== 1'b0) begin
        failures++; $display("FAIL t4_wait cyc=%0d dhit=%b merr=%b exp 0/0", k, dhit, merr);
      end
      checks++;
    end
    tick();
    if (dhit !== 1'b1 || dload !== 32'hBAD0BAD0 || merr !== 1'b1) begin
      failures++; $display("FAIL t4_hit dhit=%b dload=%h merr=%b exp 1/bad0bad0/1", dhit, dload, merr);
    end
    checks++;
    dREN = 0; ramstate = FREE;
    tick(); tick(); tick();
    if (merr !== 1'b1) begin failures++; $display("FAIL t4_sticky merr=%b exp=1", merr); end
    checks++;
    $display("test_timeout dload=%h merr=%b", dload, merr);
  endtask

  task automatic test_halt();
    halt = 1; iREN = 1; iaddr = 32'h48; ramstate = ACC; ramload = 32'hCAFE;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ramREN !== 1'b0 || ihit !== 1'b0) begin
        failures++; $display("FAIL t5_halt cyc=%0d ren=%b ihit=%b exp 0/0", k, ramREN, ihit);
      end
      checks++;
    end
    dREN = 1; daddr = 32'h300;
    tick();
    if (ramREN !== 1'b1 || ramaddr !== 32'h300) begin
      failures++; $display("FAIL t5_dread ren=%b addr=%h exp 1/300", ramREN, ramaddr);
    end
    checks++;
    tick();
    if (dhit !== 1'b1 || dload !== 32'hCAFE || ihit !== 1'b0) begin
      failures++; $display("FAIL t5_dhit dhit=%b dload=%h ihit=%b exp 1/cafe/0", dhit, dload, ihit);
    end
    checks++;
    dREN = 0; iREN = 0; halt = 0;
    tick();
    $display("test_halt dread served while halted");
  endtask

  task automatic test_reset_mid_access();
    dREN = 1; daddr = 32'h400; ramstate = BUSY; ramload = 32'h5555;
    tick();
    if (ramREN !== 1'b1) begin failures++; $display("FAIL t6_dacc ren=%b exp=1", ramREN); end
    checks++;
    #2 nRST = 1'b0;
    #1;
    if ({ramREN, ramWEN, dhit, ihit, merr} !== 5'b0 || ramaddr !== 32'h0 || dload !== 32'h0) begin
      failures++;
      $display("FAIL t6_async flags=%b addr=%h dload=%h exp 00000/0/0", {ramREN, ramWEN, dhit, ihit, merr}, ramaddr, dload);
    end
    checks++;
    tick();
    nRST = 1'b1; ramstate = ACC;
    if (ramREN !== 1'b0) begin failures++; $display("FAIL t6_idle ren=%b exp=0", ramREN); end
    checks++;
    tick();
    if (ramREN !== 1'b1 || ramaddr !== 32'h400) begin
      failures++; $display("FAIL t6_reissue ren=%b addr=%h exp 1/400", ramREN, ramaddr);
    end
    checks++;
    tick();
    if (dhit !== 1'b1 || dload !== 32'h5555) begin
      failures++; $display("FAIL t6_hit dhit=%b dload=%h exp 1/5555", dhit, dload);
    end
    checks++;
    dREN = 0;
    tick();
    $display("test_reset_mid_access reissued dload=%h", dload);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_wait_states();
    test_timeout();
    test_halt();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
